blink_pattern_receiver: RTL and testbench

Receive-side counterpart of `tickspeed_blinker`. The block watches the blinker's LED line and START strobe, samples one bit per tick period at mid-period, and rebuilds the MESSAGE_WIDTH-bit blink pattern. It sits beside the blinker in loopback benches and on the board as a self-check. It flags malformed frames instead of emitting them.

---
 rtl/blink_pattern_receiver.sv | 151 +++++++++++++++
 tb/tb_blink_pattern_receiver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/blink_pattern_receiver.sv
// Receiver for the tickspeed_blinker LED line: samples one bit per tick period at
// mid-period after a START strobe and rebuilds the MSB-first blink pattern.
module blink_pattern_receiver #(
   parameter int TICK_RATE     = 100,
   parameter int MESSAGE_WIDTH = 32
) (
   input  logic                             CLK,
   input  logic                             RST_N,
   input  logic                             LED_IN,
   input  logic                             START,
   output logic [MESSAGE_WIDTH-1:0]         pattern,
   output logic                             VALID,
   output logic                             FRAME_ERR,
   output logic                             BUSY,
   output logic [$clog2(MESSAGE_WIDTH)-1:0] bit_index
);

   localparam int TW = $clog2(TICK_RATE);
   localparam int BW = $clog2(MESSAGE_WIDTH);

   localparam logic [TW-1:0] SAMPLE_PT = TW'(TICK_RATE / 2);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_RATE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(MESSAGE_WIDTH - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } state_t;

   state_t                   r_state;
   logic [TW-1:0]            r_tick_cnt;
   logic [BW-1:0]            r_bit_cnt;
   logic [MESSAGE_WIDTH-1:0] r_sr;
   logic [MESSAGE_WIDTH-1:0] r_pattern;
   logic                     r_valid;
   logic                     r_frame_err;
   logic                     r_busy;

   state_t                   w_state_nxt;
   logic [TW-1:0]            w_tick_nxt;
   logic [BW-1:0]            w_bit_nxt;
   logic [MESSAGE_WIDTH-1:0] w_sr_smp;
   logic [MESSAGE_WIDTH-1:0] w_sr_nxt;
   logic                     w_load;
   logic                     w_valid_nxt;
   logic                     w_ferr_nxt;

   // Next-state, counter and shift-register decode for the receive FSM.
   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_sr_smp    = r_sr;
      w_sr_nxt    = r_sr;
      w_load      = 1'b0;
      w_valid_nxt = 1'b0;
      w_ferr_nxt  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_tick_nxt = {TW{1'b0}};
            w_bit_nxt  = {BW{1'b0}};
            if (START) begin
               w_state_nxt = ST_RECV;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end

         ST_RECV: begin
            // With TICK_RATE==2 the sample point is also the last tick, so the
            // end-of-frame load uses the freshly sampled value, not r_sr.
            if (r_tick_cnt == SAMPLE_PT) begin
               w_sr_smp = {r_sr[MESSAGE_WIDTH-2:0], LED_IN};
            end else begin
               w_sr_smp = r_sr;
            end

            if (r_tick_cnt == TICK_LAST) begin
               w_tick_nxt = {TW{1'b0}};
               w_bit_nxt  = r_bit_cnt + BW'(1);
            end else begin
               w_tick_nxt = r_tick_cnt + TW'(1);
               w_bit_nxt  = r_bit_cnt;
            end

            if ((r_tick_cnt == TICK_LAST) && (r_bit_cnt == BIT_LAST)) begin
               w_load      = 1'b1;
               w_valid_nxt = 1'b1;
               w_bit_nxt   = {BW{1'b0}};
               w_sr_nxt    = {MESSAGE_WIDTH{1'b0}};
               if (START) begin
                  w_state_nxt = ST_RECV;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else if (START) begin
               w_ferr_nxt  = 1'b1;
               w_tick_nxt  = {TW{1'b0}};
               w_bit_nxt   = {BW{1'b0}};
               w_sr_nxt    = {MESSAGE_WIDTH{1'b0}};
               w_state_nxt = ST_RECV;
            end else begin
               w_sr_nxt    = w_sr_smp;
               w_state_nxt = ST_RECV;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_tick_nxt  = {TW{1'b0}};
            w_bit_nxt   = {BW{1'b0}};
            w_sr_nxt    = {MESSAGE_WIDTH{1'b0}};
         end
      endcase
   end

   // State, counters, shift register and registered outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= ST_IDLE;
         r_tick_cnt  <= {TW{1'b0}};
         r_bit_cnt   <= {BW{1'b0}};
         r_sr        <= {MESSAGE_WIDTH{1'b0}};
         r_pattern   <= {MESSAGE_WIDTH{1'b0}};
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_tick_cnt  <= w_tick_nxt;
         r_bit_cnt   <= w_bit_nxt;
         r_sr        <= w_sr_nxt;
         if (w_load) begin
            r_pattern <= w_sr_smp;
         end else begin
            r_pattern <= r_pattern;
         end
         r_valid     <= w_valid_nxt;
         r_frame_err <= w_ferr_nxt;
         r_busy      <= (w_state_nxt == ST_RECV);
      end
   end

   assign pattern   = r_pattern;
   assign VALID     = r_valid;
   assign FRAME_ERR = r_frame_err;
   assign BUSY      = r_busy;
   assign bit_index = r_bit_cnt;

endmodule

// File: tb/tb_blink_pattern_receiver.sv
// Directed bench for blink_pattern_receiver: a TICK_RATE=4/MESSAGE_WIDTH=8 instance
// for the frame scenarios plus a default-parameter instance for the long frame.
module tb_blink_pattern_receiver;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b1;
   logic        LED_IN = 1'b0;
   logic        START = 1'b0;
   logic [7:0]  pattern;
   logic        VALID;
   logic        FRAME_ERR;
   logic        BUSY;
   logic [2:0]  bit_index;

   logic        d_led = 1'b0;
   logic        d_start = 1'b0;
   logic [31:0] d_pattern;
   logic        d_valid;
   logic        d_frame_err;
   logic        d_busy;
   logic [4:0]  d_bit_index;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int start_cyc = 0;
   int n_valid = 0;
   int n_ferr = 0;
   int bad_pat_chg = 0;
   logic [7:0] prev_pat = 8'h00;

   blink_pattern_receiver #(.TICK_RATE(4), .MESSAGE_WIDTH(8)) u_dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .LED_IN    (LED_IN),
      .START     (START),
      .pattern   (pattern),
      .VALID     (VALID),
      .FRAME_ERR (FRAME_ERR),
      .BUSY      (BUSY),
      .bit_index (bit_index)
   );

   blink_pattern_receiver u_dut_def (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .LED_IN    (d_led),
      .START     (d_start),
      .pattern   (d_pattern),
      .VALID     (d_valid),
      .FRAME_ERR (d_frame_err),
      .BUSY      (d_busy),
      .bit_index (d_bit_index)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Pulse bookkeeping and pattern-stability watch, sampled on the falling edge.
   always @(negedge CLK) begin
      if (VALID === 1'b1) n_valid++;
      if (FRAME_ERR === 1'b1) n_ferr++;
      if ((VALID === 1'b1) || (FRAME_ERR === 1'b1))
         check_val("valid_ferr_exclusive", 32'(VALID & FRAME_ERR), 32'h0);
      if (RST_N && (VALID !== 1'b1) && (pattern !== prev_pat)) bad_pat_chg++;
      prev_pat = pattern;
   end

   task automatic pulse_start();
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic drive_bits(input logic [7:0] data, input int nbits, input bit glitch,
                             input bit start_at_end);
      for (int k = 0; k < nbits; k++) begin
         for (int t = 0; t < 4; t++) begin
            LED_IN = (glitch && (t == 0)) ? ~data[7-k] : data[7-k];
            if (start_at_end && (k == nbits - 1) && (t == 3)) START = 1'b1;
            @(posedge CLK); #1;
            if (START) begin
               START = 1'b0;
               start_cyc = cyc;
            end
         end
      end
   endtask

   task automatic drive_default(input logic [31:0] data);
      int s_cyc;
      d_start = 1'b1;
      @(posedge CLK); #1;
      d_start = 1'b0;
      s_cyc = cyc;
      check_val("def_busy_start", 32'(d_busy), 32'h1);
      for (int k = 0; k < 32; k++) begin
         d_led = data[31-k];
         for (int t = 0; t < 100; t++) begin
            if (t == 50) check_val("def_bit_index", 32'(d_bit_index), 32'(k));
            @(posedge CLK); #1;
         end
      end
      check_val("def_valid", 32'(d_valid), 32'h1);
      check_val("def_pattern", d_pattern, 32'h5554FFFF);
      check_val("def_latency", 32'(cyc - s_cyc + 1), 32'd3201);
      check_val("def_busy_end", 32'(d_busy), 32'h0);
      check_val("def_bit_index_end", 32'(d_bit_index), 32'h0);
      @(posedge CLK); #1;
      check_val("def_valid_clear", 32'(d_valid), 32'h0);
   endtask

   initial begin
      int v0;
      int f0;
      int vc1;

      // reset values
      #2 RST_N = 1'b0;
      repeat (3) @(posedge CLK);
      #1 RST_N = 1'b1;
      check_val("rst_pattern", 32'(pattern), 32'h0);
      check_val("rst_valid", 32'(VALID), 32'h0);
      check_val("rst_ferr", 32'(FRAME_ERR), 32'h0);
      check_val("rst_busy", 32'(BUSY), 32'h0);
      check_val("rst_bit_index", 32'(bit_index), 32'h0);
      check_val("rst_def_pattern", d_pattern, 32'h0);

      // single frame 0xA5
      v0 = n_valid; f0 = n_ferr;
      pulse_start();
      check_val("a5_busy", 32'(BUSY), 32'h1);
      drive_bits(8'hA5, 8, 1'b0, 1'b0);
      check_val("a5_valid", 32'(VALID), 32'h1);
      check_val("a5_pattern", 32'(pattern), 32'hA5);
      check_val("a5_latency", 32'(cyc - start_cyc + 1), 32'd33);
      check_val("a5_busy_end", 32'(BUSY), 32'h0);
      @(posedge CLK); #1;
      check_val("a5_valid_clear", 32'(VALID), 32'h0);
      check_val("a5_valid_count", 32'(n_valid - v0), 32'd1);
      check_val("a5_ferr_count", 32'(n_ferr - f0), 32'd0);

      // back-to-back 0x3C, 0xC3
      v0 = n_valid; f0 = n_ferr;
      repeat (2) @(posedge CLK); #1;
      pulse_start();
      drive_bits(8'h3C, 8, 1'b0, 1'b1);
      vc1 = cyc;
      check_val("b2b_valid1", 32'(VALID), 32'h1);
      check_val("b2b_pattern1", 32'(pattern), 32'h3C);
      check_val("b2b_busy", 32'(BUSY), 32'h1);
      drive_bits(8'hC3, 8, 1'b0, 1'b0);
      check_val("b2b_valid2", 32'(VALID), 32'h1);
      check_val("b2b_pattern2", 32'(pattern), 32'hC3);
      check_val("b2b_spacing", 32'(cyc - vc1), 32'd32);
      @(posedge CLK); #1;
      check_val("b2b_valid_count", 32'(n_valid - v0), 32'd2);
      check_val("b2b_ferr_count", 32'(n_ferr - f0), 32'd0);

      // early START aborts a partial 0xFF
      v0 = n_valid; f0 = n_ferr;
      pulse_start();
      drive_bits(8'hFF, 3, 1'b0, 1'b0);
      pulse_start();
      check_val("early_ferr", 32'(FRAME_ERR), 32'h1);
      check_val("early_pattern_held", 32'(pattern), 32'hC3);
      check_val("early_busy", 32'(BUSY), 32'h1);
      drive_bits(8'h81, 8, 1'b0, 1'b0);
      check_val("early_valid", 32'(VALID), 32'h1);
      check_val("early_pattern", 32'(pattern), 32'h81);
      @(posedge CLK); #1;
      check_val("early_ferr_count", 32'(n_ferr - f0), 32'd1);
      check_val("early_valid_count", 32'(n_valid - v0), 32'd1);

      // glitch at tick 0 of every bit
      pulse_start();
      drive_bits(8'h5A, 8, 1'b1, 1'b0);
      check_val("glitch_valid", 32'(VALID), 32'h1);
      check_val("glitch_pattern", 32'(pattern), 32'h5A);
      @(posedge CLK); #1;

      // asynchronous reset in bit 4 of 0xFF
      pulse_start();
      drive_bits(8'hFF, 4, 1'b0, 1'b0);
      check_val("mid_bit_index", 32'(bit_index), 32'd4);
      #2 RST_N = 1'b0;
      #1;
      check_val("arst_pattern", 32'(pattern), 32'h0);
      check_val("arst_busy", 32'(BUSY), 32'h0);
      check_val("arst_bit_index", 32'(bit_index), 32'h0);
      check_val("arst_valid", 32'(VALID), 32'h0);
      check_val("arst_ferr", 32'(FRAME_ERR), 32'h0);
      @(posedge CLK); #1;
      RST_N = 1'b1;
      v0 = n_valid; f0 = n_ferr;
      repeat (2) @(posedge CLK); #1;
      pulse_start();
      drive_bits(8'h0F, 7, 1'b0, 1'b0);
      check_val("post_rst_no_valid", 32'(n_valid - v0), 32'd0);
      drive_bits(8'h0F << 7, 1, 1'b0, 1'b0);
      check_val("post_rst_valid", 32'(VALID), 32'h1);
      check_val("post_rst_pattern", 32'(pattern), 32'h0F);
      @(posedge CLK); #1;
      check_val("post_rst_valid_count", 32'(n_valid - v0), 32'd1);
      check_val("post_rst_ferr_count", 32'(n_ferr - f0), 32'd0);

      check_val("pattern_never_partial", 32'(bad_pat_chg), 32'd0);

      // default parameters
      drive_default(32'h5554FFFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
